xbar_route_scheduler: RTL and testbench
=======================================

# xbar_route_scheduler

Round-robin scheduler that shares the single-route crossbar between its input ports. Each input posts a route request (destination output and packet length in beats). The scheduler grants one request at a time and drives the crossbar's `control`/`control_val`/`control_rdy` configuration port with the winning {input, output} pair. It holds that route until the granted packet's last beat has been observed on the crossbar data path, then rotates priority.

## Interface
- `N_INPUTS`, 2: crossbar input count (≥2); `IW = $clog2(N_INPUTS)`.
- `N_OUTPUTS`, 2: crossbar output count (≥2); `OW = $clog2(N_OUTPUTS)`.
- `CONTROL_BIT_WIDTH`, 42: crossbar control word width (≥ IW+OW).
- `LEN_WIDTH`, 8: packet length field width.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_val[0:N_INPUTS-1]`  in  1 each: route request valid.
- `req_rdy[0:N_INPUTS-1]`  out  1 each: request accepted (grant).
- `req_dst[0:N_INPUTS-1]`  in  OW each: requested output port.
- `req_len[0:N_INPUTS-1]`  in  LEN_WIDTH each: packet length in beats.
- `control`  out  CONTROL_BIT_WIDTH: crossbar control word.
- `control_val`  out  1: control word valid.
- `control_rdy`  in  1: crossbar accepts control.
- `beat_val`  in  1: `send_val` of the routed crossbar output.
- `beat_rdy`  in  1: `send_rdy` of the routed crossbar output.
- `busy`  out  1: state ≠ IDLE.
- `grant_id`  out  IW: input of the current or most recent grant.

## Operation
- States: IDLE, CONFIG, XFER.
- IDLE:
  - Winner = first `i` with `req_val[i]`, searching `ptr, ptr+1, …` modulo N_INPUTS.
  - `req_rdy[winner]=1` combinationally; all other `req_rdy` are 0. No request pending → all 0.
  - On fire: latch `grant_id=winner`, `dst=req_dst[winner]`, `len=req_len[winner]`, clear beat counter, go to CONFIG.
- CONFIG:
  - `control_val=1`.
  - `control[CBW-1 -: IW]=grant_id`; `control[CBW-IW-1 -: OW]=dst`; remaining bits 0.
  - `control` is registered and stable while `control_val=1`.
  - On `control_rdy`: if `len==0`, go to IDLE (no data beats); else go to XFER.
  - Beats seen in CONFIG are ignored.
- XFER:
  - Beat = `beat_val & beat_rdy`; each beat increments the counter (LEN_WIDTH bits).
  - On the beat where counter == len-1, go to IDLE.
  - `req_rdy` is all 0 in CONFIG and XFER.
- Priority rotation: on every return to IDLE, `ptr = (grant_id+1) mod N_INPUTS`, wrapping N_INPUTS-1→0.
- Requests stay pending (no `req_rdy`) while busy. Requesters must hold `req_val`/`req_dst`/`req_len` until granted.
- Out-of-range `req_dst` (≥ N_OUTPUTS) is passed through unchanged; the crossbar behaviour for it is undefined.

## Timing
- Reset (asynchronous, any state, including mid-packet):
  - state=IDLE, `ptr=0`, `grant_id=0`, counter=0, `control=0`.
  - `control_val=0`, `busy=0`, all `req_rdy=0` while reset is asserted.
  - In-flight packet is abandoned.
- Request fire at cycle T → `control_val=1` at T+1.
- `control_rdy` high at cycle C → XFER from C+1.
  - This matches the crossbar registering its control at that edge.
  - Beats are counted from C+1.
- Last beat at cycle X → IDLE at X+1; earliest next grant at X+1.
- Minimum grant spacing with `control_rdy` tied high:
  - 3 cycles for `len=1` with a beat in the first XFER cycle.
  - 2 cycles for `len=0`.
- `busy` is registered from state; high from T+1 through the final transition edge.

## Test plan
- Reset then idle: no `req_val` → `control_val=0`, `busy=0`, all `req_rdy=0` indefinitely; `control=0`.
- Single request, N=2: input 1 requests dst 0, len 3, `control_rdy=1`.
  - `req_rdy[1]` at T; `control_val` at T+1 with `control[41]=1`, `control[40]=0`.
  - 3 beats at T+2..T+4 → `busy` falls at T+5.
- Round-robin: both inputs hold requests (len 1) continuously.
  - Grants alternate 0,1,0,1.
  - After a grant to input 1, `ptr` wraps to 0.
- Backpressure: `control_rdy=0` for 4 cycles → `control_val` and `control` held stable; XFER entered the cycle after `control_rdy` rises.
- Stalled beats and `len=0`:
  - `beat_rdy` toggled mid-packet (len 4) → exactly 4 fired beats are counted before IDLE.
  - A `len=0` request returns to IDLE the cycle after `control_rdy`.
- Reset mid-XFER after 2 of 5 beats:
  - Immediately `busy=0`, `control_val=0`.
  - After reset, input 0 wins first (`ptr=0`).

Source files
------------

// File: rtl/xbar_route_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : xbar_route_scheduler_if
//  Description : Request / crossbar-control / beat-observation bundle shared
//                between the route scheduler (slave) and its environment
//                (master: requesters, crossbar configuration port and the
//                data-path beat monitor).
//  Signals     : req_val/req_rdy/req_dst/req_len   per-input route requests
//                control/control_val/control_rdy   crossbar configuration
//                beat_val/beat_rdy                 routed output handshake
//                busy/grant_id                     scheduler status
//  Revision    : 1.0  initial release
// ============================================================================
interface xbar_route_scheduler_if #(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int LEN_WIDTH         = 8
);
    localparam int IW = $clog2(N_INPUTS);
    localparam int OW = $clog2(N_OUTPUTS);

    logic [N_INPUTS-1:0]          req_val;
    logic [N_INPUTS-1:0]          req_rdy;
    logic [OW-1:0]                req_dst [N_INPUTS];
    logic [LEN_WIDTH-1:0]         req_len [N_INPUTS];
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
    logic                         beat_val;
    logic                         beat_rdy;
    logic                         busy;
    logic [IW-1:0]                grant_id;

    modport slave (
        input  req_val, req_dst, req_len, control_rdy, beat_val, beat_rdy,
        output req_rdy, control, control_val, busy, grant_id
    );

    modport master (
        output req_val, req_dst, req_len, control_rdy, beat_val, beat_rdy,
        input  req_rdy, control, control_val, busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/xbar_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : xbar_route_scheduler
//  Description : Round-robin scheduler for a single-route crossbar. Grants one
//                input request at a time, presents the {input, output} pair on
//                the crossbar control port, then holds the route until the
//                granted packet's last beat is seen on the data path.
//  Ports       : clk    - clock
//                reset  - asynchronous active-high reset
//                sched  - xbar_route_scheduler_if.slave (requests, control,
//                         beat observation, busy/grant_id status)
//  Revision    : 1.0  initial release
// ============================================================================
module xbar_route_scheduler #(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int LEN_WIDTH         = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    xbar_route_scheduler_if.slave   sched
);
    localparam int IW = $clog2(N_INPUTS);
    localparam int OW = $clog2(N_OUTPUTS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_XFER   = 2'd2
    } state_t;

    state_t                         r_state;
    logic [IW-1:0]                  r_ptr;
    logic [IW-1:0]                  r_grant_id;
    logic [LEN_WIDTH-1:0]           r_len;
    logic [LEN_WIDTH-1:0]           r_cnt;
    logic [CONTROL_BIT_WIDTH-1:0]   r_control;
    logic                           r_control_val;
    logic                           r_busy;

    logic                           w_found;
    logic [IW-1:0]                  w_winner;
    int                             w_idx;
    logic [CONTROL_BIT_WIDTH-1:0]   w_control;
    logic                           w_beat;
    logic                           w_last_beat;
    logic [IW-1:0]                  w_next_ptr;

    // Rotating search: first valid request starting at r_ptr, modulo N_INPUTS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < N_INPUTS; k++) begin
            w_idx = (int'(r_ptr) + k) % N_INPUTS;
            if (!w_found && sched.req_val[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(w_idx);
            end
        end
    end

    // Grant is only offered while idle; reset masks it because the state
    // register is already forced to IDLE asynchronously.
    always_comb begin
        sched.req_rdy = '0;
        if ((r_state == ST_IDLE) && w_found && !reset) begin
            sched.req_rdy[w_winner] = 1'b1;
        end
    end

    // Control word: input id in the top IW bits, destination just below.
    always_comb begin
        w_control = '0;
        w_control[CONTROL_BIT_WIDTH-1 -: IW]    = w_winner;
        w_control[CONTROL_BIT_WIDTH-IW-1 -: OW] = sched.req_dst[w_winner];
    end

    assign w_beat      = sched.beat_val & sched.beat_rdy;
    assign w_last_beat = (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_next_ptr  = (r_grant_id == IW'(N_INPUTS - 1)) ? '0 : (r_grant_id + IW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_control     <= '0;
            r_control_val <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state       <= ST_CONFIG;
                        r_grant_id    <= w_winner;
                        r_len         <= sched.req_len[w_winner];
                        r_cnt         <= '0;
                        r_control     <= w_control;
                        r_control_val <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_CONFIG: begin
                    // Beats during CONFIG belong to no granted packet.
                    if (sched.control_rdy) begin
                        r_control_val <= 1'b0;
                        if (r_len == '0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ptr   <= w_next_ptr;
                        end else begin
                            r_state <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ptr   <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sched.control     = r_control;
    assign sched.control_val = r_control_val;
    assign sched.busy        = r_busy;
    assign sched.grant_id    = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_xbar_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xbar_route_scheduler
//  Description : Self-checking bench for xbar_route_scheduler (2x2, 42-bit
//                control). Table vectors, hand sequences for multi-cycle
//                corners, and randomized traffic against a transaction model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xbar_route_scheduler;
    localparam int N_IN = 2;
    localparam int N_OUT = 2;
    localparam int CBW = 42;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xbar_route_scheduler_if #(.N_INPUTS(N_IN), .N_OUTPUTS(N_OUT),
                              .CONTROL_BIT_WIDTH(CBW), .LEN_WIDTH(LW)) bus ();

    xbar_route_scheduler #(.N_INPUTS(N_IN), .N_OUTPUTS(N_OUT),
                           .CONTROL_BIT_WIDTH(CBW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .sched (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.req_val     = '0;
        bus.req_dst[0]  = '0;
        bus.req_dst[1]  = '0;
        bus.req_len[0]  = '0;
        bus.req_len[1]  = '0;
        bus.control_rdy = 1'b0;
        bus.beat_val    = 1'b0;
        bus.beat_rdy    = 1'b0;
    endtask

    // Leaves the caller just after a negedge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]     val;
        logic           d0;
        logic           d1;
        logic [1:0]     exp_rdy;
        logic           exp_gid;
        logic [CBW-1:0] exp_ctrl;
    } vec_t;

    vec_t tbl[8];

    // Transaction-level reference model state
    bit             m_busy, m_cfg;
    int             m_left, m_ptr, m_gid;
    logic [CBW-1:0] m_control;

    function automatic int pick(input logic [N_IN-1:0] v, input int p);
        for (int k = 0; k < N_IN; k++) begin
            int idx;
            idx = (p + k) % N_IN;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int grants[$];
        int gcyc[$];
        int cyc;
        int fired;
        logic [CBW-1:0] held;
        logic [N_IN-1:0] pend;
        logic           rd[N_IN];
        logic [LW-1:0]  rl[N_IN];
        logic [N_IN-1:0] exp_rdy;
        int w;

        // ptr history: 0 -> 1 -> 0 -> 0 -> 1 -> 1 -> 0 -> 0 -> 1
        tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b0, {2'b01, 40'd0}};
        tbl[1] = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1, {2'b11, 40'd0}};
        tbl[2] = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b1, {2'b10, 40'd0}};
        tbl[3] = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0, {2'b00, 40'd0}};
        tbl[4] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b0, {2'b01, 40'd0}};
        tbl[5] = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1, {2'b11, 40'd0}};
        tbl[6] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, {2'b00, 40'd0}};
        tbl[7] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b0, {2'b01, 40'd0}};

        clear_inputs();

        // ---- reset then idle ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_busy", bus.busy, 0);
            chk("idle_cval", bus.control_val, 0);
            chk("idle_rdy", bus.req_rdy, 0);
            chk("idle_ctrl", bus.control, 0);
            @(negedge clk);
        end

        // ---- table vectors (len=0, control_rdy high) ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_val     = tbl[i].val;
            bus.req_dst[0]  = tbl[i].d0;
            bus.req_dst[1]  = tbl[i].d1;
            bus.req_len[0]  = '0;
            bus.req_len[1]  = '0;
            bus.control_rdy = 1'b1;
            #1 chk("tbl_rdy", bus.req_rdy, tbl[i].exp_rdy);
            @(negedge clk);
            bus.req_val = '0;
            #1 chk("tbl_cval", bus.control_val, (tbl[i].exp_rdy != 0));
            if (tbl[i].exp_rdy != 0) begin
                chk("tbl_ctrl", bus.control, tbl[i].exp_ctrl);
                chk("tbl_gid", bus.grant_id, tbl[i].exp_gid);
            end
            @(negedge clk);
            #1 chk("tbl_idle", bus.busy, 0);
        end

        // ---- single request: input 1 -> dst 0, len 3 ----
        do_reset();
        bus.req_val = 2'b10; bus.req_dst[1] = 1'b0; bus.req_len[1] = 8'd3;
        bus.control_rdy = 1'b1; bus.beat_val = 1'b1; bus.beat_rdy = 1'b1;
        #1 chk("single_rdy_T", bus.req_rdy, 2'b10);
        @(negedge clk);
        bus.req_val = '0;
        #1 chk("single_cval_T1", bus.control_val, 1);
        chk("single_ctrl41", bus.control[41], 1);
        chk("single_ctrl40", bus.control[40], 0);
        chk("single_busy_T1", bus.busy, 1);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            #1 chk("single_busy_xfer", bus.busy, 1);
            chk("single_cval_xfer", bus.control_val, 0);
        end
        @(negedge clk);
        #1 chk("single_busy_T5", bus.busy, 0);

        // ---- round robin: both inputs hold len-1 requests ----
        do_reset();
        bus.req_val = 2'b11; bus.req_len[0] = 8'd1; bus.req_len[1] = 8'd1;
        bus.control_rdy = 1'b1; bus.beat_val = 1'b1; bus.beat_rdy = 1'b1;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            #1;
            if (bus.req_rdy != 0) begin
                grants.push_back(bus.req_rdy[1] ? 1 : 0);
                gcyc.push_back(cyc);
            end
            @(negedge clk);
            cyc++;
        end
        chk("rr_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) begin
            chk("rr_order", grants[i], i % 2);
            if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 3);
        end

        // ---- control backpressure ----
        do_reset();
        bus.req_val = 2'b01; bus.req_dst[0] = 1'b1; bus.req_len[0] = 8'd2;
        bus.control_rdy = 1'b0; bus.beat_val = 1'b1; bus.beat_rdy = 1'b1;
        @(negedge clk);
        bus.req_val = '0;
        #1 held = bus.control;
        chk("bp_ctrl_val", held, {2'b01, 40'd0});
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            #1 chk("bp_cval_hold", bus.control_val, 1);
            chk("bp_ctrl_hold", bus.control, {2'b01, 40'd0});
        end
        @(negedge clk);
        bus.control_rdy = 1'b1;
        #1 chk("bp_cval_rdy", bus.control_val, 1);
        @(negedge clk);
        bus.control_rdy = 1'b0;
        #1 chk("bp_xfer_cval", bus.control_val, 0);
        chk("bp_xfer_busy", bus.busy, 1);
        @(negedge clk);
        #1 chk("bp_beat2_busy", bus.busy, 1);
        @(negedge clk);
        #1 chk("bp_done", bus.busy, 0);

        // ---- stalled beats, len 4 ----
        do_reset();
        bus.req_val = 2'b01; bus.req_len[0] = 8'd4;
        bus.control_rdy = 1'b1; bus.beat_val = 1'b1; bus.beat_rdy = 1'b1;
        @(negedge clk);
        bus.req_val = '0; bus.beat_rdy = 1'b0;
        fired = 0;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            bus.beat_rdy = ((cyc % 3) != 1);
            #1;
            if (!bus.busy) break;
            if (bus.beat_val && bus.beat_rdy) fired++;
            cyc++;
        end
        chk("stall_beats", fired, 4);
        chk("stall_timeout", (cyc < 30), 1);

        // ---- len 0 with delayed control_rdy ----
        do_reset();
        bus.req_val = 2'b10; bus.req_len[1] = 8'd0; bus.control_rdy = 1'b0;
        @(negedge clk);
        bus.req_val = '0;
        #1 chk("len0_cval", bus.control_val, 1);
        @(negedge clk);
        bus.control_rdy = 1'b1;
        #1 chk("len0_cval2", bus.control_val, 1);
        @(negedge clk);
        bus.control_rdy = 1'b0;
        #1 chk("len0_busy", bus.busy, 0);
        chk("len0_cval_off", bus.control_val, 0);

        // ---- reset mid-XFER after 2 of 5 beats ----
        do_reset();
        bus.req_val = 2'b01; bus.control_rdy = 1'b1;       // len 0 grant to 0 -> ptr 1
        @(negedge clk);
        bus.req_val = '0;
        @(negedge clk);
        bus.req_val = 2'b10; bus.req_len[1] = 8'd5;
        bus.beat_val = 1'b1; bus.beat_rdy = 1'b1;
        #1 chk("mid_rdy1", bus.req_rdy, 2'b10);
        @(negedge clk);                                      // CONFIG
        bus.req_val = '0;
        @(negedge clk);                                      // beat 1
        @(negedge clk);                                      // beat 2
        @(negedge clk);
        #1 chk("mid_busy_pre", bus.busy, 1);
        bus.req_val = 2'b11; bus.req_len[0] = '0; bus.req_len[1] = '0;
        #1 reset = 1'b1;
        #1 chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cval", bus.control_val, 0);
        chk("mid_rst_rdy", bus.req_rdy, 0);
        chk("mid_rst_ctrl", bus.control, 0);
        chk("mid_rst_gid", bus.grant_id, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_after_rdy", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_val = '0;
        #1 chk("mid_after_gid", bus.grant_id, 0);
        chk("mid_after_cval", bus.control_val, 1);

        // ---- randomized traffic against transaction model ----
        do_reset();
        m_busy = 0; m_cfg = 0; m_left = 0; m_ptr = 0; m_gid = 0; m_control = '0;
        pend = '0;
        for (int i = 0; i < N_IN; i++) begin rd[i] = 0; rl[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_IN; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    rd[i]   = 1'($urandom % N_OUT);
                    rl[i]   = LW'($urandom_range(0, 3));
                end
                bus.req_dst[i] = rd[i];
                bus.req_len[i] = rl[i];
            end
            bus.req_val     = pend;
            bus.control_rdy = ($urandom % 4 != 0);
            bus.beat_val    = ($urandom % 4 != 0);
            bus.beat_rdy    = ($urandom % 3 != 0);

            exp_rdy = '0;
            w = m_busy ? -1 : pick(pend, m_ptr);
            if (w >= 0) exp_rdy[w] = 1'b1;

            #1;
            chk("rnd_rdy", bus.req_rdy, exp_rdy);
            chk("rnd_cval", bus.control_val, m_cfg);
            chk("rnd_busy", bus.busy, m_busy);
            chk("rnd_gid", bus.grant_id, m_gid);
            chk("rnd_ctrl", bus.control, m_control);

            if (w >= 0) begin
                m_busy = 1; m_cfg = 1; m_gid = w; m_left = int'(rl[w]);
                m_control = '0;
                m_control[41] = 1'(w);
                m_control[40] = rd[w];
                pend[w] = 1'b0;
            end else if (m_cfg) begin
                if (bus.control_rdy) begin
                    m_cfg = 0;
                    if (m_left == 0) begin m_busy = 0; m_ptr = (m_gid + 1) % N_IN; end
                end
            end else if (m_busy && bus.beat_val && bus.beat_rdy) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_ptr = (m_gid + 1) % N_IN; end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
